// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data SRAM arbiter, data-priority, fixed-latency accesses; optional stall counter under ARB_STALL_CNT_EN
module mem_arbiter #(
   parameter int WAIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        freeze,
   output logic        sram_en,
   output logic        sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, RESP} state_t;

   // Counter runs WAIT_CYCLES-1 down to 0, so an access holds the SRAM for WAIT_CYCLES cycles
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        sram_en_q, sram_en_d;
   logic        sram_we_q, sram_we_d;
   logic        if_ready_q, if_ready_d;
   logic        mem_ready_q, mem_ready_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;

   logic        data_req;

   assign data_req = mem_r_en | mem_w_en;

   // Next-state: requests are only looked at in IDLE, data beats fetch, sram_we_q doubles as the latched write flag
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      sram_en_d   = sram_en_q;
      sram_we_d   = sram_we_q;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         IDLE: begin
            if (data_req) begin
               state_d   = D_ACC;
               addr_d    = mem_addr;
               wdata_d   = mem_wdata;
               cnt_d     = CNT_LOAD;
               sram_en_d = 1'b1;
               sram_we_d = mem_w_en;
            end else if (if_req) begin
               state_d   = IF_ACC;
               addr_d    = if_addr;
               wdata_d   = 32'h0;
               cnt_d     = CNT_LOAD;
               sram_en_d = 1'b1;
               sram_we_d = 1'b0;
            end
         end
         IF_ACC, D_ACC: begin
            if (cnt_q == 4'd0) begin
               if (state_q == IF_ACC) begin
                  if_rdata_d = sram_rdata;
                  if_ready_d = 1'b1;
               end else begin
                  if (!sram_we_q) begin
                     mem_rdata_d = sram_rdata;
                  end
                  mem_ready_d = 1'b1;
               end
               state_d   = RESP;
               sram_en_d = 1'b0;
               sram_we_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            sram_en_d = 1'b0;
            sram_we_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset kills an in-flight access at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         sram_en_q   <= 1'b0;
         sram_we_q   <= 1'b0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
         if_rdata_q  <= 32'h0;
         mem_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         sram_en_q   <= sram_en_d;
         sram_we_q   <= sram_we_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign if_rdata   = if_rdata_q;
   assign if_ready   = if_ready_q;
   assign mem_rdata  = mem_rdata_q;
   assign mem_ready  = mem_ready_q;
   assign sram_en    = sram_en_q;
   assign sram_we    = sram_we_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;

   // Stall is released in the same cycle the matching ready pulse appears
   assign freeze = (if_req & ~if_ready_q) | (data_req & ~mem_ready_q);

`ifdef ARB_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   // Saturating count of frozen cycles
   always_comb begin
      stall_d = stall_q;
      if (freeze && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   // Stall counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 32'h0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'h0;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter WAIT_CYCLES, default 4, SHALL set the SRAM access length in cycles; the legal range is 1..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port if_req, input, 1 bit: instruction-fetch request; held until if_ready.
REQ-006 Port if_addr, input, 32 bits: fetch byte address.
REQ-007 Port if_rdata, output, 32 bits: fetched instruction (registered).
REQ-008 Port if_ready, output, 1 bit: one-cycle fetch-complete pulse.
REQ-009 Port mem_r_en, input, 1 bit: MEM-stage load request.
REQ-010 Port mem_w_en, input, 1 bit: MEM-stage store request.
REQ-011 Port mem_addr, input, 32 bits: data byte address.
REQ-012 Port mem_wdata, input, 32 bits: store data.
REQ-013 Port mem_rdata, output, 32 bits: load data (registered).
REQ-014 Port mem_ready, output, 1 bit: one-cycle data-complete pulse.
REQ-015 Port freeze, output, 1 bit: pipeline stall.
REQ-016 Port sram_en, output, 1 bit: SRAM access active.
REQ-017 Port sram_we, output, 1 bit: SRAM write strobe.
REQ-018 Port sram_addr, output, 32 bits: SRAM address.
REQ-019 Port sram_wdata, output, 32 bits: SRAM write data.
REQ-020 Port sram_rdata, input, 32 bits: SRAM read data.
REQ-021 Port stall_cycles, output, 32 bits: stall counter (see Configuration).

Function
REQ-022 The FSM SHALL have the states IDLE, IF_ACC, D_ACC and RESP.
REQ-023 In IDLE, a data request (mem_r_en|mem_w_en) SHALL go to D_ACC; else if_req SHALL go to IF_ACC; else the FSM SHALL stay in IDLE.
REQ-024 When data and fetch requests are simultaneous, data SHALL win and the fetch SHALL be served in the next IDLE.
REQ-025 On grant, the address and write data SHALL be latched and the down-counter loaded with WAIT_CYCLES-1.
REQ-026 In ?_ACC, sram_en=1 and sram_addr/sram_wdata SHALL come from the latched values.
REQ-027 In D_ACC, sram_we SHALL equal the latched write flag; it SHALL be 0 in IF_ACC.
REQ-028 In ?_ACC with counter 0: sram_rdata SHALL be captured into if_rdata or mem_rdata (loads/fetches only), and the FSM SHALL go to RESP.
REQ-029 Otherwise in ?_ACC, the counter SHALL decrement.
REQ-030 In RESP, exactly one of if_ready/mem_ready SHALL be 1 for that cycle, then the FSM SHALL return to IDLE; requests SHALL be ignored in RESP.
REQ-031 Latency from a request seen in IDLE to the ready pulse SHALL be WAIT_CYCLES+1 cycles; back-to-back accesses SHALL be WAIT_CYCLES+2 cycles apart.
REQ-032 Accesses SHALL be non-preemptive: a request arriving during ?_ACC SHALL wait.
REQ-033 When mem_r_en and mem_w_en are both set, the access SHALL be a write; mem_rdata SHALL be unchanged.
REQ-034 freeze SHALL equal (if_req & ~if_ready) | ((mem_r_en|mem_w_en) & ~mem_ready), combinationally.
REQ-035 Request inputs SHALL be sampled only in IDLE; addresses changing during an access SHALL be ignored.

Reset
REQ-036 rst SHALL force state IDLE and clear the counter, if_rdata, mem_rdata and stall_cycles to 0.
REQ-037 After reset, if_ready, mem_ready, sram_en and sram_we SHALL be 0.
REQ-038 Reset mid-access SHALL drop sram_en/sram_we immediately (asynchronously) and SHALL produce no ready pulse.

Configuration
REQ-039 Macro ARB_STALL_CNT_EN SHALL select the stall counter.
REQ-040 With ARB_STALL_CNT_EN defined, stall_cycles SHALL increment each cycle freeze=1, saturating at 32'hFFFFFFFF.
REQ-041 Without ARB_STALL_CNT_EN, stall_cycles SHALL be tied to 0 and no counter logic SHALL be built.

Verification (WAIT_CYCLES=4)
REQ-042 Single fetch: if_req=1 @ if_addr=0x10 in IDLE at cycle 0, sram_rdata=0xE3A00001 -> sram_en=1 in cycles 1-4, if_ready=1 in cycle 5, if_rdata=0xE3A00001, freeze=1 in cycles 0-4.
REQ-043 Collision: if_req and mem_r_en both rise at cycle 0 -> mem_ready at cycle 5, IF_ACC entered at cycle 7, if_ready at cycle 11.
REQ-044 Store: mem_w_en=1, mem_addr=0x400, mem_wdata=0xDEADBEEF -> sram_we=1 with those values for 4 cycles; mem_ready at cycle 5; mem_rdata unchanged.
REQ-045 Reset mid-access: rst asserted in cycle 2 of D_ACC -> sram_en=0 in the same cycle, no mem_ready, state IDLE.
REQ-046 WAIT_CYCLES=1 with ARB_STALL_CNT_EN: a single load -> mem_ready at cycle 2, stall_cycles=2; without the macro, stall_cycles stays 0.
